ofdm_cp_remover: RTL and testbench

- Stage directly downstream of the Schmidl-Cox detector, running in the ce_clk domain inside the same RFNoC block.
- Takes the sc16 sample stream plus a start-of-frame (SOF) marker, which flags the detected preamble/timing index.
- For each frame, strips the cyclic prefix from each OFDM symbol and forwards exactly fft_len useful samples per symbol for num_symbols symbols. Output goes to the FFT/equalizer stage, with tlast marking each symbol.
- Samples outside a frame are discarded.

---
 rtl/ofdm_cp_remover.sv | 151 +++++++++++++++
 tb/tb_ofdm_cp_remover.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_cp_remover.sv
// Cyclic-prefix remover: after a start-of-frame marker, drops cp_len samples and
// forwards fft_len samples per symbol for num_symbols symbols, tlast per symbol.
module ofdm_cp_remover #(
    parameter int ITEM_W = 32,
    parameter int LEN_W  = 12,
    parameter int SYM_W  = 8
) (
    input  logic              ce_clk,
    input  logic              ce_rst,
    input  logic [LEN_W-1:0]  cfg_fft_len,
    input  logic [LEN_W-1:0]  cfg_cp_len,
    input  logic [SYM_W-1:0]  cfg_num_symbols,
    input  logic [ITEM_W-1:0] s_axis_tdata,
    input  logic              s_axis_tuser,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [ITEM_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [15:0]       frame_count,
    output logic [15:0]       abort_count,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, SKIP, PASS} state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [SYM_W-1:0] SYM_ONE = SYM_W'(1);

    state_t            state;
    logic [LEN_W-1:0]  fft_len, cp_len, cp_cnt, s_cnt;
    logic [SYM_W-1:0]  num_sym, sym_cnt;

    logic              blocked, accept, sof_ok, sof_fwd, fwd, adv;
    logic              sym_end, frame_end, tlast_abort, next_cp_zero;
    logic [LEN_W-1:0]  cur_fft, cur_s;
    logic [SYM_W-1:0]  cur_num, cur_sym;

    always_comb begin
        blocked = m_axis_tvalid && !m_axis_tready;
        // A zero-CP SOF is forwarded straight from IDLE/SKIP, so it must wait for a free slot too.
        if (ce_rst)
            s_axis_tready = 1'b0;
        else if (state == PASS)
            s_axis_tready = !blocked;
        else
            s_axis_tready = !(blocked && s_axis_tuser && (cfg_cp_len == '0));

        accept  = s_axis_tvalid && s_axis_tready;
        sof_ok  = s_axis_tuser && (cfg_fft_len != '0) && (cfg_num_symbols != '0);
        sof_fwd = sof_ok && (cfg_cp_len == '0);

        cur_fft = sof_fwd ? cfg_fft_len     : fft_len;
        cur_num = sof_fwd ? cfg_num_symbols : num_sym;
        cur_s   = sof_fwd ? '0              : s_cnt;
        cur_sym = sof_fwd ? '0              : sym_cnt;
        next_cp_zero = sof_fwd || (cp_len == '0);

        sym_end     = (cur_s + LEN_ONE) == cur_fft;
        frame_end   = sym_end && (cur_sym == cur_num - SYM_ONE);
        tlast_abort = !s_axis_tuser && s_axis_tlast && !frame_end;

        fwd = accept && (s_axis_tuser ? sof_fwd : (state == PASS));
        adv = fwd && (s_axis_tuser || !tlast_abort);
    end

    always_ff @(posedge ce_clk) begin
        if (ce_rst) begin
            state         <= IDLE;
            fft_len       <= '0;
            cp_len        <= '0;
            num_sym       <= '0;
            cp_cnt        <= '0;
            s_cnt         <= '0;
            sym_cnt       <= '0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            frame_count   <= '0;
            abort_count   <= '0;
        end else begin
            if (m_axis_tvalid && m_axis_tready)
                m_axis_tvalid <= 1'b0;

            if (fwd) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tlast  <= sym_end || tlast_abort;
                m_axis_tuser  <= frame_end || tlast_abort;
            end

            if (accept) begin
                if (s_axis_tuser) begin
                    if (state != IDLE)
                        abort_count <= abort_count + 16'd1;
                    fft_len <= cfg_fft_len;
                    cp_len  <= cfg_cp_len;
                    num_sym <= cfg_num_symbols;
                    sym_cnt <= '0;
                    s_cnt   <= '0;
                    cp_cnt  <= LEN_ONE;
                    if (!sof_ok)
                        state <= IDLE;
                    else begin
                        frame_count <= frame_count + 16'd1;
                        if (cfg_cp_len == LEN_ONE)
                            state <= PASS;
                        else if (cfg_cp_len != '0)
                            state <= SKIP;
                    end
                end else if (state == SKIP) begin
                    if (s_axis_tlast) begin
                        abort_count <= abort_count + 16'd1;
                        state       <= IDLE;
                    end else begin
                        cp_cnt <= cp_cnt + LEN_ONE;
                        if (cp_cnt + LEN_ONE == cp_len) begin
                            s_cnt <= '0;
                            state <= PASS;
                        end
                    end
                end else if (state == PASS && tlast_abort) begin
                    abort_count <= abort_count + 16'd1;
                    state       <= IDLE;
                end

                // Shared symbol/frame bookkeeping for both PASS samples and a zero-CP SOF.
                if (adv) begin
                    if (frame_end)
                        state <= IDLE;
                    else if (sym_end) begin
                        sym_cnt <= cur_sym + SYM_ONE;
                        s_cnt   <= '0;
                        cp_cnt  <= '0;
                        state   <= next_cp_zero ? PASS : SKIP;
                    end else begin
                        s_cnt <= cur_s + LEN_ONE;
                        state <= PASS;
                    end
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ofdm_cp_remover.sv
// Scoreboard bench for ofdm_cp_remover: expected outputs come from a positional
// frame model (symbol period arithmetic) and are checked by an independent monitor.
module tb_ofdm_cp_remover;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] cfg_fft = '0, cfg_cp = '0;
    logic [7:0]  cfg_num = '0;
    logic [31:0] s_data = '0;
    logic        s_user = 1'b0, s_last = 1'b0, s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_last, m_user, m_valid;
    logic        m_ready = 1'b1;
    logic [15:0] frame_count, abort_count;
    logic        busy;

    ofdm_cp_remover #(.ITEM_W(32), .LEN_W(12), .SYM_W(8)) dut (
        .ce_clk(clk), .ce_rst(rst),
        .cfg_fft_len(cfg_fft), .cfg_cp_len(cfg_cp), .cfg_num_symbols(cfg_num),
        .s_axis_tdata(s_data), .s_axis_tuser(s_user), .s_axis_tlast(s_last),
        .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
        .m_axis_tdata(m_data), .m_axis_tlast(m_last), .m_axis_tuser(m_user),
        .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
        .frame_count(frame_count), .abort_count(abort_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
        logic        u;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   stall_pct = 0;

    localparam int MAXN = 512;
    logic [31:0] sd [MAXN];
    logic        su [MAXN];
    logic        sl [MAXN];
    int          cf [MAXN];
    int          cc [MAXN];
    int          cn [MAXN];

    function automatic void push_exp(logic [31:0] d, logic l, logic u);
        exp_t e;
        e.d = d; e.l = l; e.u = u;
        sb.push_back(e);
    endfunction

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endfunction

    // Frame model: a frame occupies num*(cp+fft) input positions from its SOF; position k is
    // useful when (k mod period) >= cp. A later SOF or a non-final input tlast truncates it.
    function automatic void run_model(input int n, output int frames, output int aborts);
        int i, p, per, total, stop, kind;
        i = 0; frames = 0; aborts = 0;
        while (i < n) begin
            if (!su[i]) begin i++; continue; end
            p = i;
            if (cf[p] == 0 || cn[p] == 0) begin i++; continue; end
            frames++;
            per = cc[p] + cf[p];
            total = cn[p] * per;
            stop = -1; kind = 0;
            for (int k = 1; k < total && stop < 0; k++) begin
                if (p + k >= n)                       begin stop = k; kind = 3; end
                else if (su[p + k])                   begin stop = k; kind = 1; end
                else if (sl[p + k] && k != total - 1) begin stop = k; kind = 2; end
            end
            if (stop < 0) stop = total;
            for (int k = 0; k < stop; k++)
                if (k % per >= cc[p])
                    push_exp(sd[p + k], (k % per) == per - 1, k == total - 1);
            case (kind)
                0: i = p + total;
                1: begin aborts++; i = p + stop; end
                2: begin
                    if (stop % per >= cc[p]) push_exp(sd[p + stop], 1'b1, 1'b1);
                    aborts++;
                    i = p + stop + 1;
                end
                default: i = n;
            endcase
        end
    endfunction

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m_valid && m_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: got data 0x%0h last %0b user %0b, expected none",
                                 m_data, m_last, m_user);
                    end else begin
                        e = sb.pop_front();
                        if (m_data !== e.d || m_last !== e.l || m_user !== e.u) begin
                            errors++;
                            $display("FAIL output: got data 0x%0h last %0b user %0b, expected data 0x%0h last %0b user %0b",
                                     m_data, m_last, m_user, e.d, e.l, e.u);
                        end
                    end
                end
                if (!s_ready) begin
                    checks++;
                    if (!(m_valid && !m_ready)) begin
                        errors++;
                        $display("FAIL ready_low_with_free_slot: got s_ready 0 with m_valid %0b m_ready %0b, expected slot full",
                                 m_valid, m_ready);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = ($urandom_range(99) >= stall_pct);
        end
    end

    function automatic void clear_seg(int n, int f, int c, int s);
        for (int i = 0; i < n; i++) begin
            sd[i] = i; su[i] = 1'b0; sl[i] = 1'b0;
            cf[i] = f; cc[i] = c; cn[i] = s;
        end
    endfunction

    task automatic send(input int i);
        int waitc = 0;
        s_data = sd[i]; s_user = su[i]; s_last = sl[i];
        cfg_fft = 12'(cf[i]); cfg_cp = 12'(cc[i]); cfg_num = 8'(cn[i]);
        s_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            waitc++;
            if (waitc > 500) begin
                checks++; errors++;
                $display("FAIL accept_timeout: got no s_ready in %0d cycles, expected acceptance", waitc);
                break;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        cfg_fft = 12'($urandom_range(20));
        cfg_cp = 12'($urandom_range(6));
        cfg_num = 8'($urandom_range(4));
    endtask

    task automatic drain();
        int c = 0;
        while ((sb.size() != 0 || m_valid) && c < 3000) begin
            @(negedge clk); c++;
        end
        checks++;
        if (sb.size() != 0 || m_valid) begin
            errors++;
            $display("FAIL drain_timeout: got %0d outputs still pending, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_seg(input string name, input int n, input int gap_pct, input logic exp_busy);
        int frames, aborts;
        run_model(n, frames, aborts);
        for (int i = 0; i < n; i++) begin
            if (int'($urandom_range(99)) < gap_pct) begin @(posedge clk); #1; end
            send(i);
        end
        drain();
        check({name, "_frame_count"}, 32'(frame_count), 32'(frames));
        check({name, "_abort_count"}, 32'(abort_count), 32'(aborts));
        check({name, "_busy"}, 32'(busy), 32'(exp_busy));
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input logic hold_valid);
        @(posedge clk); #1;
        rst = 1'b1;
        s_valid = hold_valid; s_user = 1'b1; cfg_fft = 12'd4; cfg_cp = 12'd0; cfg_num = 8'd1;
        @(negedge clk);
        check("reset_s_ready", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; s_valid = 1'b0; s_user = 1'b0;
        @(negedge clk);
        check("reset_m_valid", 32'(m_valid), 32'd0);
        check("reset_m_flags", {30'd0, m_last, m_user}, 32'd0);
        check("reset_m_data", m_data, 32'd0);
        check("reset_counts", {frame_count, abort_count}, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        do_reset(1'b0);

        clear_seg(200, 16, 4, 3); su[100] = 1'b1;
        stall_pct = 0;  run_seg("basic", 200, 0, 1'b0);
        do_reset(1'b0);
        clear_seg(200, 16, 4, 3); su[100] = 1'b1;
        stall_pct = 25; run_seg("backpressure", 200, 0, 1'b0);
        do_reset(1'b0);

        clear_seg(40, 8, 0, 2); su[10] = 1'b1;
        stall_pct = 0;  run_seg("zero_cp", 40, 0, 1'b0);
        do_reset(1'b0);

        clear_seg(200, 16, 4, 3); su[100] = 1'b1; su[130] = 1'b1;
        run_seg("sof_abort", 200, 0, 1'b0);
        do_reset(1'b0);

        clear_seg(200, 16, 4, 3); su[100] = 1'b1; sl[110] = 1'b1; su[150] = 1'b1; cf[150] = 0;
        run_seg("tlast_abort", 200, 0, 1'b0);
        do_reset(1'b0);

        clear_seg(27, 16, 4, 3); su[5] = 1'b1;
        run_seg("pre_reset", 27, 0, 1'b1);
        do_reset(1'b1);
        clear_seg(200, 16, 4, 3); su[100] = 1'b1;
        stall_pct = 25; run_seg("post_reset", 200, 10, 1'b0);

        for (int r = 0; r < 8; r++) begin
            do_reset(1'b0);
            n = 300;
            for (int i = 0; i < n; i++) begin
                sd[i] = $urandom;
                su[i] = (i < 230) && ($urandom_range(99) < 3);
                sl[i] = (i < 230) && ($urandom_range(99) < 1);
                cf[i] = ($urandom_range(99) < 5) ? 0 : int'($urandom_range(12, 1));
                cc[i] = int'($urandom_range(4));
                cn[i] = ($urandom_range(99) < 5) ? 0 : int'($urandom_range(3, 1));
            end
            su[0] = 1'b1; cf[0] = 5; cn[0] = 2;
            stall_pct = (r % 2 == 0) ? 25 : 0;
            run_seg("random", n, (r % 3 == 0) ? 20 : 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
